// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory responder.
package imem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 32;
  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;
endpackage

// File: rtl/imem_array.sv
// imem_array: synchronous RAM, one write port and one registered read port.
// A read and write to the same index on one edge returns the old word.
module imem_array
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clock1,
  input  logic              reset1,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_q, rd_d;
  always_comb rd_d = re ? mem[raddr] : rd_q;
  always_ff @(posedge clock1)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clock1 or negedge reset1)
    if (!reset1) rd_q <= '0;
    else rd_q <= rd_d;
  assign rdata = rd_q;
endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: fixed-latency instruction fetch responder over imem_array.
// Define IMEM_BOUNDS_CHECK_EN to reject addresses above the array with rsp_err.
module inst_mem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int DATA_W  = IMEM_DATA_W,
  parameter int LATENCY = 3
) (
  input  logic              clock1,
  input  logic              reset1,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_inst,
  output logic              rsp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic oor_q, oor_d, nop_q, nop_d;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic accept, rd_go, oor_now;
  logic [DATA_W-1:0] rd_data;
`ifdef IMEM_BOUNDS_CHECK_EN
  assign oor_now = |req_addr[31:ADDR_W];
`else
  logic unused_hi;
  assign oor_now = 1'b0;
  assign unused_hi = ^req_addr[31:ADDR_W];
`endif
  always_comb begin
    accept      = state_q == IDLE && req_valid;
    rd_go       = (accept && LATENCY == 1) || (state_q == WAIT && cnt_q == 4'd1);
    idx_d       = accept ? req_addr[ADDR_W-1:0] : idx_q;
    oor_d       = accept ? oor_now : oor_q;
    cnt_d       = accept ? LAT_M1 : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    state_d     = accept ? (LATENCY == 1 ? RESP : WAIT)
                : state_q == WAIT ? (cnt_q == 4'd1 ? RESP : WAIT) : IDLE;
    nop_d       = rd_go ? oor_d : nop_q;
    rsp_err_d   = rd_go & oor_d;
    req_ready_d = state_d == IDLE;
    rsp_valid_d = state_d == RESP;
  end
  always_ff @(posedge clock1 or negedge reset1)
    if (!reset1) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      oor_q       <= 1'b0;
      nop_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      oor_q       <= oor_d;
      nop_q       <= nop_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  // LATENCY==1 reads on the accept edge, so the index comes straight from the request
  imem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clock1(clock1),
    .reset1(reset1),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (rd_go & ~oor_d),
    .raddr (idx_d),
    .rdata (rd_data)
  );
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_inst  = nop_q ? DATA_W'(IMEM_NOP) : rd_data;
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder: randomized and directed checks against a cycle-count reference model.
module tb_inst_mem_responder;
  localparam int L = 3;
  logic clock1 = 1'b0, reset1;
  logic req_valid, load_en, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr, rsp_inst, load_data;
  logic [7:0] load_addr;
  int n_vec = 0, n_err = 0;
  int cyc = 0, next_ok = 0, read_cyc = -1;
  logic [31:0] mem_m [256];
  logic [31:0] p_addr = 32'h0, exp_inst = 32'h0;
  logic exp_valid = 1'b0, exp_err = 1'b0, exp_ready = 1'b1;
`ifdef IMEM_BOUNDS_CHECK_EN
  bit oor_en = 1'b1;
`else
  bit oor_en = 1'b0;
`endif

  inst_mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(L)) dut (
    .clock1(clock1), .reset1(reset1),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clock1 = ~clock1;

  // Drive one cycle at the negedge and advance the model across the following posedge.
  // The responder is free again LATENCY+1 edges after an accept; the read happens
  // LATENCY-1 edges after it and sees memory before that edge's own write.
  task automatic step(input logic v, input logic [31:0] a, input logic le,
                      input logic [7:0] la, input logic [31:0] ld);
    req_valid = v; req_addr = a; load_en = le; load_addr = la; load_data = ld;
    @(posedge clock1);
    if (v && cyc >= next_ok) begin
      p_addr = a; read_cyc = cyc + L - 1; next_ok = cyc + L + 1;
    end
    exp_valid = (cyc == read_cyc);
    exp_err = exp_valid && oor_en && (p_addr[31:8] != 24'h0);
    if (exp_valid) exp_inst = exp_err ? 32'h0 : mem_m[p_addr[7:0]];
    if (le) mem_m[la] = ld;
    exp_ready = (cyc + 1 >= next_ok);
    cyc++;
    @(negedge clock1);
    req_valid = 1'b0; load_en = 1'b0;
  endtask

  task automatic test_reset();
    reset1 = 1'b0; req_valid = 1'b0; req_addr = 32'h0; load_en = 1'b0;
    load_addr = 8'h0; load_data = 32'h0;
    repeat (5) @(negedge clock1);
    n_vec++;
    if ({req_ready, rsp_valid, rsp_err, rsp_inst} !== {3'b100, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state rdy=%b vld=%b err=%b inst=%h want rdy=1 vld=0 err=0 inst=0",
               req_ready, rsp_valid, rsp_err, rsp_inst);
    end
    reset1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
      n_vec++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL idle_after_reset cyc=%0d vld=%b rdy=%b want vld=0 rdy=1", cyc, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 256; i++) step(1'b0, 32'h0, 1'b1, 8'(i), $urandom);
  endtask

  task automatic test_basic_read();
    step(1'b0, 32'h0, 1'b1, 8'd5, 32'h2001_0004);
    step(1'b1, 32'd5, 1'b0, 8'h0, 32'h0);
    for (int j = 1; j <= 4; j++) begin
      step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
      n_vec++;
      if ({req_ready, rsp_valid, rsp_err, rsp_inst} !== {exp_ready, exp_valid, exp_err, exp_inst}) begin
        n_err++;
        $display("FAIL basic_read j=%0d got rdy=%b vld=%b err=%b inst=%h want rdy=%b vld=%b err=%b inst=%h",
                 j, req_ready, rsp_valid, rsp_err, rsp_inst, exp_ready, exp_valid, exp_err, exp_inst);
      end
      n_vec++;
      if (j == 2 && (rsp_valid !== 1'b1 || rsp_inst !== 32'h2001_0004)) begin
        n_err++;
        $display("FAIL basic_read_data vld=%b inst=%h want vld=1 inst=20010004", rsp_valid, rsp_inst);
      end
    end
  endtask

  task automatic test_sequential();
    int i = 0, got = 0, last = 0;
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 8'(k), 32'hA000_0000 + k);
    for (int b = 0; b < 80 && got < 8; b++) begin
      bit acc = (i < 8) && (cyc >= next_ok);
      step(i < 8, 32'(i), 1'b0, 8'h0, 32'h0);
      if (acc) i++;
      n_vec++;
      if ({req_ready, rsp_valid, rsp_err, rsp_inst} !== {exp_ready, exp_valid, exp_err, exp_inst}) begin
        n_err++;
        $display("FAIL sequential cyc=%0d got rdy=%b vld=%b inst=%h want rdy=%b vld=%b inst=%h",
                 cyc, req_ready, rsp_valid, rsp_inst, exp_ready, exp_valid, exp_inst);
      end
      if (rsp_valid === 1'b1) begin
        n_vec++;
        if (rsp_inst !== 32'hA000_0000 + got || (got > 0 && cyc - last != L + 1)) begin
          n_err++;
          $display("FAIL sequential_order n=%0d inst=%h gap=%0d want inst=%h gap=%0d",
                   got, rsp_inst, cyc - last, 32'hA000_0000 + got, L + 1);
        end
        last = cyc; got++;
      end
    end
    n_vec++;
    if (got != 8) begin
      n_err++;
      $display("FAIL sequential_count got=%0d want=8", got);
    end
  endtask

  task automatic test_collision();
    step(1'b0, 32'h0, 1'b1, 8'd3, 32'h1234_5678);
    step(1'b1, 32'd3, 1'b0, 8'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 8'd3, 32'hFFFF_0000);
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_inst !== 32'h1234_5678 || rsp_inst !== exp_inst) begin
      n_err++;
      $display("FAIL collision_old vld=%b inst=%h want vld=1 inst=12345678", rsp_valid, rsp_inst);
    end
    step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    step(1'b1, 32'd3, 1'b0, 8'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_inst !== 32'hFFFF_0000) begin
      n_err++;
      $display("FAIL collision_new vld=%b inst=%h want vld=1 inst=ffff0000", rsp_valid, rsp_inst);
    end
    step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'd2, 1'b0, 8'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    reset1 = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, rsp_valid, rsp_err, rsp_inst} !== {3'b100, 32'h0}) begin
      n_err++;
      $display("FAIL reset_mid_state rdy=%b vld=%b err=%b inst=%h want rdy=1 vld=0 err=0 inst=0",
               req_ready, rsp_valid, rsp_err, rsp_inst);
    end
    repeat (2) @(negedge clock1);
    reset1 = 1'b1;
    read_cyc = -1; next_ok = cyc; exp_inst = 32'h0; exp_err = 1'b0; exp_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
      n_vec++;
      if ({req_ready, rsp_valid, rsp_err, rsp_inst} !== {3'b100, 32'h0}) begin
        n_err++;
        $display("FAIL reset_mid_after j=%0d rdy=%b vld=%b err=%b inst=%h want rdy=1 vld=0 err=0 inst=0",
                 j, req_ready, rsp_valid, rsp_err, rsp_inst);
      end
    end
  endtask

  task automatic test_bounds();
    step(1'b1, 32'h0000_0105, 1'b0, 8'h0, 32'h0);
    for (int j = 1; j <= 3; j++) begin
      step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
      n_vec++;
      if ({req_ready, rsp_valid, rsp_err, rsp_inst} !== {exp_ready, exp_valid, exp_err, exp_inst}) begin
        n_err++;
        $display("FAIL bounds j=%0d got rdy=%b vld=%b err=%b inst=%h want rdy=%b vld=%b err=%b inst=%h",
                 j, req_ready, rsp_valid, rsp_err, rsp_inst, exp_ready, exp_valid, exp_err, exp_inst);
      end
    end
    step(1'b1, 32'h0000_0105, 1'b0, 8'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_err !== oor_en || rsp_inst !== (oor_en ? 32'h0 : 32'hA000_0005)) begin
      n_err++;
      $display("FAIL bounds_result vld=%b err=%b inst=%h want vld=1 err=%b inst=%h",
               rsp_valid, rsp_err, rsp_inst, oor_en, oor_en ? 32'h0 : 32'hA000_0005);
    end
    step(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15));
      step($urandom_range(0, 2) != 0, a, $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 15)), $urandom);
      n_vec++;
      if ({req_ready, rsp_valid, rsp_err, rsp_inst} !== {exp_ready, exp_valid, exp_err, exp_inst}) begin
        n_err++;
        $display("FAIL random cyc=%0d got rdy=%b vld=%b err=%b inst=%h want rdy=%b vld=%b err=%b inst=%h",
                 cyc, req_ready, rsp_valid, rsp_err, rsp_inst, exp_ready, exp_valid, exp_err, exp_inst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic_read();
    test_sequential();
    test_collision();
    test_reset_mid();
    test_bounds();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Instruction-memory responder serving the fetch stage: accepts a word-address fetch request, performs a fixed-latency read of a synchronous instruction array, and returns the 32-bit instruction with a one-cycle valid strobe.
- Includes a write/load port so a bench or boot loader can program the program image before or during execution.
- Sits between the fetch stage's PC output and its instruction input, and replaces a testbench-driven instruction bus.

Parameters:
- ADDR_W, 8, array index width; depth = 2**ADDR_W words.
- DATA_W, 32, instruction width.
- LATENCY, 3, cycles from request accept to rsp_valid; legal range 1..15.

Ports:
- clock1  input  1  system clock, rising edge.
- reset1  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_addr  input  32  word address; PC increments by 1 per instruction.
- req_ready  output  1  responder can accept a request this cycle.
- rsp_valid  output  1  one-cycle strobe; rsp_inst valid.
- rsp_inst  output  DATA_W  returned instruction, held until next response.
- rsp_err  output  1  qualifies rsp_valid; address out of range (feature only).
- load_en  input  1  write strobe for the array.
- load_addr  input  ADDR_W  write index.
- load_data  input  DATA_W  write data.

Behaviour:
- Reset (reset1 low, async):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_inst=0, rsp_err=0, latency counter=0.
  - Array contents are NOT reset.
- States: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - req_valid sampled high at edge T: latch req_addr, load counter=LATENCY-1, go to WAIT (LATENCY=1: go directly to RESP).
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - At counter==1, read the array at the latched index on that edge; go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle (cycle T+LATENCY); rsp_inst and rsp_err update on entry.
  - req_ready=0; next state IDLE. Back-to-back throughput is one request per LATENCY+1 cycles.
- rsp_inst holds the last value while rsp_valid=0. No backpressure: the consumer must sample on the strobe.
- Index = req_addr[ADDR_W-1:0]. Upper address bits are ignored unless the feature is enabled.
- Load port:
  - Independent of the state machine; writes on any edge with load_en=1, including during WAIT.
  - A write and a read to the same index on the same edge: the read returns OLD data (read-before-write).
  - A write before the read edge is visible to that response.
- req_valid while req_ready=0 is ignored, not queued; the requester must hold or re-issue.
- Reset asserted in WAIT/RESP aborts the access. No rsp_valid appears after reset release.

Optional Feature:
- Macro: IMEM_BOUNDS_CHECK_EN.
- Enabled:
  - If req_addr[31:ADDR_W] != 0, the array is not read.
  - The response returns rsp_inst=IMEM_NOP (32'h0000_0000) with rsp_err=1 for the rsp_valid cycle, at the same latency.
  - rsp_err=0 on in-range responses.
- Disabled:
  - Addresses wrap modulo depth.
  - rsp_err is tied to 0.

Decomposition:
- Shared package imem_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - IMEM_NOP constant
  - default DATA_W and ADDR_W constants
- One sub-module, imem_array: a single-port-read/single-port-write synchronous RAM with read-before-write semantics.
- The FSM, counter and bounds check stay in the top module.

Test Plan:
- Reset/defaults: hold reset1=0 for 5 cycles -> req_ready=1, rsp_valid=0, rsp_inst=0; no strobe for 10 cycles after release with req_valid=0.
- Basic read: load addr 5=32'h2001_0004; request addr 5 at edge T -> rsp_valid only at T+3, rsp_inst=32'h2001_0004, req_ready low T+1..T+3, high at T+4.
- Sequential fetch: preload addr 0..7 with 32'hA000_0000+i; request addr 0..7 as soon as req_ready is high -> eight strobes spaced 4 cycles apart, data in order.
- Load collision: read edge for addr 3 coincides with load_en to addr 3 (new=32'hFFFF_0000, old=32'h1234_5678) -> rsp_inst=32'h1234_5678; a later read returns 32'hFFFF_0000.
- Reset mid-access: request addr 2, drop reset1 during WAIT -> outputs at reset values immediately; no rsp_valid after release.
- Bounds (IMEM_BOUNDS_CHECK_EN, ADDR_W=8): request addr 32'h0000_0105 -> rsp_inst=0, rsp_err=1. Without the macro -> returns the contents of index 5, rsp_err=0.
